// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler: FSM states, grant sources
// and sticky error bit positions.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      BUSY
   } state_e;

   typedef enum logic {
      SRC_CPU,
      SRC_ECHO
   } src_e;

   localparam int unsigned ERR_OVF  = 0;
   localparam int unsigned ERR_ECHO = 1;
   localparam int unsigned ERR_TMO  = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for CPU transmit data. A push while full is dropped; fullness is
// judged on the registered count, before any same-cycle pop.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: round-robin between the CPU FIFO and a one-byte echo
// register, driving the TX_EN / TX_STATUS handshake toward the UART Sender.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned ACK_TIMEOUT = 2048
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cpu_wr,
   input  logic [7:0]               cpu_data,
   input  logic                     echo_req,
   input  logic [7:0]               echo_data,
   input  logic                     tx_status,
   output logic                     tx_en,
   output logic [7:0]               tx_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     fifo_full,
   output logic                     echo_pend,
   output logic                     tx_busy,
   output logic [2:0]               err,
   input  logic                     err_clr
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;

   state_e        state_q, state_d;
   src_e          last_q, last_d;
   logic          tx_en_q, tx_en_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          echo_pend_q, echo_pend_d;
   logic [7:0]    echo_data_q, echo_data_d;
   logic [2:0]    err_q, err_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic          fifo_pop;
   logic          fifo_empty;
   logic [7:0]    fifo_rdata;
   logic          grant_echo;
   logic [2:0]    err_new;

   uart_tx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (cpu_wr),
      .push_data (cpu_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign tx_en     = tx_en_q;
   assign tx_data   = tx_data_q;
   assign echo_pend = echo_pend_q;
   assign tx_busy   = (state_q != IDLE);
   assign err       = err_q;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      tx_en_d     = tx_en_q;
      tx_data_d   = tx_data_q;
      echo_pend_d = echo_pend_q;
      echo_data_d = echo_data_q;
      tmo_d       = tmo_q;
      fifo_pop    = 1'b0;
      grant_echo  = 1'b0;
      err_new     = '0;

      case (state_q)
         IDLE: begin
            if (tx_status && (!fifo_empty || echo_pend_q)) begin
               // On a tie the source that did not win last time gets the grant.
               if (!fifo_empty && echo_pend_q) begin
                  grant_echo = (last_q == SRC_CPU);
               end else begin
                  grant_echo = echo_pend_q;
               end
               if (grant_echo) begin
                  tx_data_d = echo_data_q;
                  last_d    = SRC_ECHO;
               end else begin
                  tx_data_d = fifo_rdata;
                  fifo_pop  = 1'b1;
                  last_d    = SRC_CPU;
               end
               tx_en_d = 1'b1;
               tmo_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (!tx_status) begin
               tx_en_d = 1'b0;
               state_d = BUSY;
            end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
               tx_en_d          = 1'b0;
               err_new[ERR_TMO] = 1'b1;
               state_d          = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         BUSY: begin
            if (tx_status) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new echo byte landing while the old one is being granted is not an overrun.
      if (echo_req) begin
         if (echo_pend_q && !grant_echo) begin
            err_new[ERR_ECHO] = 1'b1;
         end
         echo_pend_d = 1'b1;
         echo_data_d = echo_data;
      end else if (grant_echo) begin
         echo_pend_d = 1'b0;
      end

      if (cpu_wr && fifo_full) begin
         err_new[ERR_OVF] = 1'b1;
      end

      err_d = (err_clr ? 3'b000 : err_q) | err_new;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= SRC_ECHO;
         tx_en_q     <= 1'b0;
         tx_data_q   <= '0;
         echo_pend_q <= 1'b0;
         echo_data_q <= '0;
         err_q       <= '0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         tx_en_q     <= tx_en_d;
         tx_data_q   <= tx_data_d;
         echo_pend_q <= echo_pend_d;
         echo_data_q <= echo_data_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
      end
   end

endmodule
